lsu_data_mem: RTL

//  Byte-addressable data memory with RISC-V load/store semantics: takes funct3-encoded
//  LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake and performs lane

---
 rtl/lsu_data_mem.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lsu_data_mem.sv
// rtl/lsu_data_mem.sv - byte-addressable RISC-V load/store data memory
// Clears every word after reset, then serves one request per cycle with fixed RD_LAT response latency.
module lsu_data_mem #(
  parameter int XLEN    = 32,
  parameter int MEM_LEN = 256,
  parameter int RD_LAT  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_misalign_o,
  output logic            resp_fault_o
);

  localparam int AW = $clog2(MEM_LEN);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [MEM_LEN];

  logic            accept, illegal, in_range, misalign, fault, do_store;
  logic [XLEN-3:0] widx;
  logic [1:0]      off;
  logic [AW-1:0]   waddr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_sh, rword, lane, ld_data, rdata_new;

  logic [RD_LAT-1:0] pv_q, pm_q, pf_q;
  logic [XLEN-1:0]   prd_q [RD_LAT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gating with rst_i keeps a request from slipping in on the reset edge.
  assign req_ready_o = (state_q == S_RUN) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    widx     = req_addr_i[XLEN-1:2];
    off      = req_addr_i[1:0];
    waddr    = widx[AW-1:0];
    in_range = (widx >> AW) == '0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we_i;
      default:                illegal = 1'b1;
    endcase
    misalign = ((req_funct3_i[1:0] == 2'b01) && off[0]) ||
               ((req_funct3_i[1:0] == 2'b10) && (off != 2'b00));
    fault    = illegal || !in_range;
    do_store = accept && req_we_i && !fault && !misalign;
    case (req_funct3_i[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    wdata_sh = req_wdata_i << {off, 3'b000};
    rword    = mem_q[waddr];
    lane     = rword >> {off, 3'b000};
    case (req_funct3_i)
      3'b000:  ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: ld_data = lane;
    endcase
    rdata_new = (accept && !req_we_i && !fault && !misalign) ? ld_data : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (do_store) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_q[waddr][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 is loaded at the accept edge, the last stage drives the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= '0;
      pm_q <= '0;
      pf_q <= '0;
      for (int i = 0; i < RD_LAT; i++) prd_q[i] <= '0;
    end else begin
      pv_q[0]  <= accept;
      pm_q[0]  <= accept && !fault && misalign;
      pf_q[0]  <= accept && fault;
      prd_q[0] <= rdata_new;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pm_q[i]  <= pm_q[i-1];
        pf_q[i]  <= pf_q[i-1];
        prd_q[i] <= prd_q[i-1];
      end
    end
  end

  assign resp_valid_o    = pv_q[RD_LAT-1];
  assign resp_rdata_o    = prd_q[RD_LAT-1];
  assign resp_misalign_o = pm_q[RD_LAT-1];
  assign resp_fault_o    = pf_q[RD_LAT-1];

endmodule
